// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem/writeback control FSM for the RV32 core,
// owning the PC and halting on debug traps, misaligned jump targets or a memory watchdog.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    input  logic        dec_mem_load,
    input  logic        dec_mem_store,
    input  logic        dec_write_en,
    input  logic        dec_jump_en,
    input  logic [1:0]  dec_debug,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] load_data,
    output logic [1:0]  rf_wsel,
    output logic        rf_we,
    output logic        halted,
    output logic [1:0]  status
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    logic [2:0]  state;
    logic [15:0] wait_cnt;
    logic [31:0] target;
    logic        take;
    logic        misaligned;

    // reset gates the request combinationally so an in-flight access is dropped at once
    assign mem_req    = (state == FETCH || state == MEM) && !reset;
    assign mem_we     = state == MEM && dec_mem_store;
    assign mem_addr   = state == MEM ? alu_result : pc;
    assign pc_plus4   = pc + 32'd4;
    assign take       = dec_jump_en && (dec_write_en || alu_result[0]);
    assign target     = take ? pc + imm : pc_plus4;
    assign misaligned = take && target[1];
    assign rf_we      = state == WB && dec_write_en && !misaligned;
    assign rf_wsel    = dec_mem_load ? 2'b01 : (dec_write_en && dec_jump_en) ? 2'b10 : 2'b00;
    assign halted     = state == HALT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            instr     <= '0;
            load_data <= '0;
            wait_cnt  <= '0;
            status    <= 2'b00;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH, MEM: begin
                    if (mem_ready) begin
                        if (state == FETCH) instr <= mem_rdata;
                        else if (dec_mem_load) load_data <= mem_rdata;
                        state <= state == FETCH ? DECODE : WB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state  <= HALT;
                        status <= 2'b11;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DECODE: state <= EXEC;
                EXEC: begin
                    if (dec_debug != 2'b00) begin
                        state  <= HALT;
                        status <= dec_debug == 2'b01 ? 2'b01 : 2'b10;
                    end else begin
                        state <= (dec_mem_load || dec_mem_store) ? MEM : WB;
                    end
                end
                WB: begin
                    if (misaligned) begin
                        state  <= HALT;
                        status <= 2'b10;
                    end else begin
                        pc    <= target;
                        state <= FETCH;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table vectors, randomized instructions against a per-instruction model,
// and hand sequences for reset behaviour of the sequencer.
module tb_cpu_sequencer;
    localparam logic [31:0] RPC = 32'h100;
    localparam int          TMO = 4;

    typedef struct {
        logic        ld, st, we, jmp;
        logic [1:0]  dbg;
        logic [31:0] imm, alu, rdata;
        int          fd, md;
        logic [31:0] exp_pc;
        int          exp_cyc, exp_pulses;
        logic [1:0]  exp_wsel, exp_status;
        logic        exp_halt;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_rdata = '0, instr;
    logic        dec_mem_load = 1'b0, dec_mem_store = 1'b0, dec_write_en = 1'b0, dec_jump_en = 1'b0;
    logic [1:0]  dec_debug = 2'b00, rf_wsel, status;
    logic [31:0] imm = '0, alu_result = '0, pc, pc_plus4, load_data;
    logic        rf_we, halted;

    int          n_checks = 0, n_fail = 0;
    logic [31:0] cur_pc;
    vec_t        tbl[16];

    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(RPC), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instr(instr),
        .dec_mem_load(dec_mem_load), .dec_mem_store(dec_mem_store), .dec_write_en(dec_write_en),
        .dec_jump_en(dec_jump_en), .dec_debug(dec_debug), .imm(imm), .alu_result(alu_result),
        .pc(pc), .pc_plus4(pc_plus4), .load_data(load_data), .rf_wsel(rf_wsel), .rf_we(rf_we),
        .halted(halted), .status(status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] f, input logic [1:0] dbg, input logic [31:0] im,
                                input logic [31:0] alu, input logic [31:0] rd, input int fd, input int md,
                                input logic [31:0] epc, input int ecyc, input int epul,
                                input logic [1:0] ewsel, input logic [1:0] estat, input logic ehalt);
        vec_t v;
        {v.ld, v.st, v.we, v.jmp} = f;
        v.dbg = dbg; v.imm = im; v.alu = alu; v.rdata = rd; v.fd = fd; v.md = md;
        v.exp_pc = epc; v.exp_cyc = ecyc; v.exp_pulses = epul;
        v.exp_wsel = ewsel; v.exp_status = estat; v.exp_halt = ehalt;
        return v;
    endfunction

    // instruction-level reference: phase costs and PC rules, no state machine
    function automatic vec_t model(input vec_t vi, input logic [31:0] p);
        vec_t v;
        int c;
        logic tk;
        logic [31:0] t;
        v = vi;
        v.exp_pc = p; v.exp_pulses = 0; v.exp_halt = 1'b1; v.exp_status = 2'd0;
        v.exp_wsel = v.ld ? 2'd1 : (v.we && v.jmp) ? 2'd2 : 2'd0;
        if (v.fd >= TMO) begin v.exp_cyc = TMO; v.exp_status = 2'd3; return v; end
        c = v.fd + 3;
        if (v.dbg != 2'd0) begin v.exp_cyc = c; v.exp_status = v.dbg == 2'd1 ? 2'd1 : 2'd2; return v; end
        if (v.ld || v.st) begin
            if (v.md >= TMO) begin v.exp_cyc = c + TMO; v.exp_status = 2'd3; return v; end
            c += v.md + 1;
        end
        v.exp_cyc = c + 1;
        tk = v.jmp && (v.we || v.alu[0]);
        t = tk ? p + v.imm : p + 32'd4;
        if (tk && t[1]) begin v.exp_status = 2'd2; return v; end
        v.exp_halt = 1'b0; v.exp_pc = t; v.exp_pulses = v.we ? 1 : 0;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_pc", pc, RPC);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_status", 32'(status), 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_load_data", load_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cur_pc = RPC;
    endtask

    task automatic run(input vec_t v);
        logic [31:0] start, iw;
        logic [1:0]  wsel_seen;
        int          cyc, rc, pulses, bad, hb;
        logic        gap;
        start = cur_pc; iw = $urandom; wsel_seen = 2'd0;
        cyc = 0; rc = 0; pulses = 0; bad = 0; hb = 0; gap = 1'b0;
        {dec_mem_load, dec_mem_store, dec_write_en, dec_jump_en} = {v.ld, v.st, v.we, v.jmp};
        dec_debug = v.dbg; imm = v.imm; alu_result = v.alu;
        #1;
        check("pc_start", pc, start);
        check("pc_plus4", pc_plus4, start + 32'd4);
        while (pc == start && !halted && cyc < 40) begin
            if (rf_we) begin pulses++; wsel_seen = rf_wsel; end
            if (mem_req) begin
                if (gap) bad += int'(mem_addr != v.alu || mem_we != v.st);
                else bad += int'(mem_addr != start || mem_we);
                mem_ready = rc >= (gap ? v.md : v.fd);
                mem_rdata = gap ? v.rdata : iw;
                rc++;
            end else begin
                mem_ready = 1'b0; rc = 0; gap = 1'b1;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        mem_ready = 1'b0;
        check("cycles", 32'(cyc), 32'(v.exp_cyc));
        check("rf_we_pulses", 32'(pulses), 32'(v.exp_pulses));
        if (v.exp_pulses > 0) check("rf_wsel", 32'(wsel_seen), 32'(v.exp_wsel));
        check("mem_bus", 32'(bad), 32'd0);
        check("halted", 32'(halted), 32'(v.exp_halt));
        check("status", 32'(status), 32'(v.exp_status));
        check("pc_next", pc, v.exp_pc);
        if (v.fd < TMO) check("instr", instr, iw);
        if (v.ld && v.dbg == 2'd0 && v.md < TMO && v.fd < TMO) check("load_data", load_data, v.rdata);
        if (v.exp_halt) begin
            repeat (3) begin
                @(negedge clk);
                #1;
                if (mem_req || rf_we || !halted || pc != start) hb++;
            end
            check("halt_frozen", 32'(hb), 32'd0);
            do_reset();
        end else begin
            cur_pc = v.exp_pc;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(4'b0010, 2'd0, 32'h0, 32'h5, 32'h0, 0, 0, 32'h104, 4, 1, 2'd0, 2'd0, 1'b0);
        tbl[1]  = mk(4'b0010, 2'd0, 32'h0, 32'h9, 32'h0, 0, 0, 32'h108, 4, 1, 2'd0, 2'd0, 1'b0);
        tbl[2]  = mk(4'b1010, 2'd0, 32'h0, 32'h40, 32'hdeadbeef, 0, 3, 32'h10c, 8, 1, 2'd1, 2'd0, 1'b0);
        tbl[3]  = mk(4'b0100, 2'd0, 32'h0, 32'h44, 32'h0, 0, 0, 32'h110, 5, 0, 2'd0, 2'd0, 1'b0);
        tbl[4]  = mk(4'b0011, 2'd0, 32'hf0, 32'h0, 32'h0, 0, 0, 32'h200, 4, 1, 2'd2, 2'd0, 1'b0);
        tbl[5]  = mk(4'b0011, 2'd0, 32'h10, 32'h0, 32'h0, 0, 0, 32'h210, 4, 1, 2'd2, 2'd0, 1'b0);
        tbl[6]  = mk(4'b0001, 2'd0, 32'h40, 32'h0, 32'h0, 0, 0, 32'h214, 4, 0, 2'd0, 2'd0, 1'b0);
        tbl[7]  = mk(4'b0001, 2'd0, 32'hfffffff8, 32'h1, 32'h0, 0, 0, 32'h20c, 4, 0, 2'd0, 2'd0, 1'b0);
        tbl[8]  = mk(4'b0010, 2'd0, 32'h0, 32'h3, 32'h0, 2, 0, 32'h210, 6, 1, 2'd0, 2'd0, 1'b0);
        tbl[9]  = mk(4'b0011, 2'd0, 32'hfffffff2, 32'h0, 32'h0, 0, 0, 32'h210, 4, 0, 2'd2, 2'd2, 1'b1);
        tbl[10] = mk(4'b0010, 2'd1, 32'h0, 32'h0, 32'h0, 0, 0, 32'h100, 3, 0, 2'd0, 2'd1, 1'b1);
        tbl[11] = mk(4'b0100, 2'd3, 32'h0, 32'h0, 32'h0, 0, 0, 32'h100, 3, 0, 2'd0, 2'd2, 1'b1);
        tbl[12] = mk(4'b1010, 2'd0, 32'h0, 32'h80, 32'h1234, 0, 4, 32'h100, 7, 0, 2'd1, 2'd3, 1'b1);
        tbl[13] = mk(4'b0001, 2'd0, 32'h6, 32'h1, 32'h0, 0, 0, 32'h100, 4, 0, 2'd0, 2'd2, 1'b1);
        tbl[14] = mk(4'b0011, 2'd0, 32'hffffff00, 32'h0, 32'h0, 0, 0, 32'h0, 4, 1, 2'd2, 2'd0, 1'b0);
        tbl[15] = mk(4'b0010, 2'd0, 32'h0, 32'h0, 32'h0, 4, 0, 32'h0, 4, 0, 2'd0, 2'd3, 1'b1);

        do_reset();
        for (int i = 0; i < 16; i++) run(tbl[i]);

        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int k;
            logic [31:0] r;
            k = int'($urandom_range(0, 4));
            v = mk(4'b0000, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 2'd0, 2'd0, 1'b0);
            v.ld = k == 1; v.st = k == 2; v.we = k == 0 || k == 1 || k == 3; v.jmp = k == 3 || k == 4;
            r = $urandom;
            v.imm = (r & ~32'h3) | 32'h4;
            if ($urandom_range(0, 7) == 0) v.imm = v.imm | 32'h2;
            v.alu = $urandom; v.rdata = $urandom;
            v.dbg = $urandom_range(0, 9) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
            v.fd = $urandom_range(0, 19) == 0 ? TMO : int'($urandom_range(0, 3));
            v.md = $urandom_range(0, 9) == 0 ? TMO : int'($urandom_range(0, 3));
            run(model(v, cur_pc));
        end

        do_reset();
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, RPC);
        {dec_mem_load, dec_mem_store, dec_write_en, dec_jump_en} = 4'b1010;
        dec_debug = 2'd0; alu_result = 32'h300; mem_rdata = 32'h55;
        mem_ready = 1'b1;
        @(negedge clk); #1; mem_ready = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("mid_mem_req", 32'(mem_req), 32'd1);
        check("mid_mem_addr", mem_addr, 32'h300);
        reset = 1'b1;
        #1;
        check("reset_drop_req", 32'(mem_req), 32'd0);
        check("reset_drop_pc", pc, RPC);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", mem_addr, RPC);
        check("restart_load_data", load_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
